// File: rtl/io_responder.sv
// rtl/io_responder.sv - core IO responder: RX byte FIFO to read words, write words to TX bytes
// Optional build macro IO_LOOPBACK_EN routes written bytes straight into the RX FIFO.
module io_responder #(
    parameter int RX_DEPTH_LOG2 = 4,
    parameter int WORD_BYTES    = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        io_ren,
    input  logic        io_wen,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    output logic        io_done,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_overflow,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int                     DEPTH    = 1 << RX_DEPTH_LOG2;
    localparam logic [RX_DEPTH_LOG2:0] FULL_CNT = (RX_DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [RX_DEPTH_LOG2:0] CNT_ONE  = (RX_DEPTH_LOG2 + 1)'(1);
    localparam logic [RX_DEPTH_LOG2-1:0] PTR_ONE = RX_DEPTH_LOG2'(1);
    localparam logic [2:0]             LAST_IDX = 3'(WORD_BYTES - 1);

    typedef enum logic [1:0] {IDLE, RD_COLLECT, WR_SEND, DONE} state_t;

    state_t state, state_nxt;

    logic [7:0]               mem [DEPTH];
    logic [RX_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [RX_DEPTH_LOG2:0]   count;
    logic                     fifo_full, fifo_empty;
    logic                     push_req, push, pop, drop;
    logic [7:0]               push_data, pop_data;

    logic [2:0]  idx, sel;
    logic [31:0] wword, shreg, wshift;
    logic [7:0]  wbyte;
    logic        last_byte, wr_step;

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign pop_data   = mem[rd_ptr];
    assign pop        = (state == RD_COLLECT) && !fifo_empty;

    // Byte order on the wire is MSB first, so the selector counts down from the top byte.
    assign last_byte = (idx == LAST_IDX);
    assign sel       = LAST_IDX - idx;
    assign wshift    = wword >> {sel, 3'b000};
    assign wbyte     = wshift[7:0];

`ifdef IO_LOOPBACK_EN
    logic unused_loopback;
    assign unused_loopback = &{1'b0, rx_valid, rx_data, tx_ready};
    assign push_req  = (state == WR_SEND);
    assign push_data = wbyte;
    assign wr_step   = (state == WR_SEND) && !fifo_full;
    assign drop      = 1'b0;
`else
    assign push_req  = rx_valid;
    assign push_data = rx_data;
    assign wr_step   = (state == WR_SEND) && tx_ready;
    assign drop      = push_req && fifo_full && !pop;
`endif

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push = push_req && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (drop) begin
                rx_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        io_done   = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        case (state)
            IDLE: begin
                if (io_wen) begin
                    state_nxt = WR_SEND;
                end else if (io_ren) begin
                    state_nxt = RD_COLLECT;
                end
            end
            RD_COLLECT: begin
                if (pop && last_byte) begin
                    state_nxt = DONE;
                end
            end
            WR_SEND: begin
`ifndef IO_LOOPBACK_EN
                tx_valid = 1'b1;
                tx_data  = wbyte;
`endif
                if (wr_step && last_byte) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                io_done   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            idx      <= '0;
            wword    <= '0;
            shreg    <= '0;
            io_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (io_wen) begin
                        wword <= io_wdata;
                        idx   <= '0;
                    end else if (io_ren) begin
                        shreg <= '0;
                        idx   <= '0;
                    end
                end
                RD_COLLECT: begin
                    if (pop) begin
                        shreg <= {shreg[23:0], pop_data};
                        idx   <= idx + 3'd1;
                        if (last_byte) begin
                            io_rdata <= {shreg[23:0], pop_data};
                        end
                    end
                end
                WR_SEND: begin
                    if (wr_step) begin
                        idx <= idx + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_io_responder.sv
// tb/tb_io_responder.sv - directed self-checking bench for io_responder
// Define IO_LOOPBACK_EN for both DUT and bench to exercise the loopback build.
module tb_io_responder;

    logic        clk = 1'b0;
    logic        rstn;
    logic        io_ren, io_wen;
    logic [31:0] io_wdata, io_rdata;
    logic        io_done;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_overflow;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;

    int passed = 0;
    int total  = 0;

    io_responder dut (
        .clk        (clk),
        .rstn       (rstn),
        .io_ren     (io_ren),
        .io_wen     (io_wen),
        .io_wdata   (io_wdata),
        .io_rdata   (io_rdata),
        .io_done    (io_done),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_overflow(rx_overflow),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick;
        rx_valid = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [31:0] exp_word, input int exp_lat);
        int n;
        io_ren = 1'b1;
        tick;
        io_ren = 1'b0;
        n = 1;
        while (!io_done && n < 60) begin
            tick;
            n++;
        end
        check({tag, "_done"}, 32'(io_done), 32'd1);
        check({tag, "_data"}, io_rdata, exp_word);
        if (exp_lat > 0) check({tag, "_lat"}, 32'(n), 32'(exp_lat));
        tick;
        check({tag, "_done_once"}, 32'(io_done), 32'd0);
    endtask

    task automatic do_write(input string tag, input logic [31:0] w, input bit toggle);
        logic [7:0] exp_b [4];
        logic [7:0] held;
        bit         stalled;
        int         got, cyc;
        exp_b   = '{w[31:24], w[23:16], w[15:8], w[7:0]};
        stalled = 1'b0;
        held    = 8'h00;
        got     = 0;
        cyc     = 0;
        io_wdata = w;
        io_wen   = 1'b1;
        tick;
        io_wen = 1'b0;
        while (got < 4 && cyc < 40) begin
            tx_ready = toggle ? cyc[0] : 1'b1;
            if (stalled) check({tag, "_stable"}, 32'(tx_data), 32'(held));
            stalled = tx_valid && !tx_ready;
            held    = tx_data;
            if (tx_valid && tx_ready) begin
                check({tag, "_byte"}, 32'(tx_data), 32'(exp_b[got]));
                got++;
            end
            tick;
            cyc++;
        end
        tx_ready = 1'b0;
        check({tag, "_count"}, 32'(got), 32'd4);
        check({tag, "_done"}, 32'(io_done), 32'd1);
        check({tag, "_valid_off"}, 32'(tx_valid), 32'd0);
        tick;
        check({tag, "_done_once"}, 32'(io_done), 32'd0);
    endtask

    initial begin
        int n;
        bit seen;
        rstn     = 1'b0;
        io_ren   = 1'b0;
        io_wen   = 1'b0;
        io_wdata = '0;
        rx_valid = 1'b0;
        rx_data  = '0;
        tx_ready = 1'b0;
        tick;
        tick;
        check("rst_rdata", io_rdata, 32'd0);
        check("rst_done", 32'(io_done), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_overflow", 32'(rx_overflow), 32'd0);
        rstn = 1'b1;
        tick;

`ifdef IO_LOOPBACK_EN
        io_wdata = 32'hCAFEF00D;
        io_wen   = 1'b1;
        tick;
        io_wen = 1'b0;
        n      = 1;
        seen   = 1'b0;
        while (!io_done && n < 40) begin
            if (tx_valid) seen = 1'b1;
            tick;
            n++;
        end
        check("lb_wr_done", 32'(io_done), 32'd1);
        check("lb_tx_never", 32'(seen), 32'd0);
        tick;
        do_read("lb_rd", 32'hCAFEF00D, 5);
        check("lb_overflow", 32'(rx_overflow), 32'd0);
`else
        // Basic read with a pre-filled FIFO.
        push_byte(8'h12);
        push_byte(8'h34);
        push_byte(8'h56);
        push_byte(8'h78);
        do_read("rd1", 32'h12345678, 5);

        // Write with a stalling TX.
        do_write("wr1", 32'hDEADBEEF, 1'b1);

        // Overflow: 17th byte dropped, first 16 survive in order.
        for (int i = 0; i < 16; i++) push_byte(8'h40 + 8'(i));
        check("ovf_at_16", 32'(rx_overflow), 32'd0);
        push_byte(8'hEE);
        check("ovf_at_17", 32'(rx_overflow), 32'd1);
        do_read("ovf_rd0", 32'h40414243, 5);
        do_read("ovf_rd1", 32'h44454647, 5);
        do_read("ovf_rd2", 32'h48494A4B, 5);
        do_read("ovf_rd3", 32'h4C4D4E4F, 5);
        check("ovf_sticky", 32'(rx_overflow), 32'd1);

        // Read waiting on a slow byte stream.
        io_ren = 1'b1;
        tick;
        io_ren = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            if (io_done) seen = 1'b1;
            tick;
            if (io_done) seen = 1'b1;
            push_byte(8'hA1 + 8'(k * 8'h11));
            if (io_done) seen = 1'b1;
        end
        check("slow_no_early", 32'(seen), 32'd0);
        tick;
        check("slow_done", 32'(io_done), 32'd1);
        check("slow_data", io_rdata, 32'hA1B2C3D4);
        tick;

        // Simultaneous request: write wins, FIFO untouched.
        push_byte(8'h99);
        io_ren = 1'b1;
        do_write("both", 32'h01020304, 1'b0);
        io_ren = 1'b0;
        push_byte(8'hAA);
        push_byte(8'hBB);
        push_byte(8'hCC);
        do_read("both_rd", 32'h99AABBCC, 5);

        // Reset in the middle of a write.
        io_wdata = 32'h55667788;
        io_wen   = 1'b1;
        tick;
        io_wen   = 1'b0;
        tx_ready = 1'b1;
        check("mid_byte0", 32'(tx_data), 32'h55);
        tick;
        check("mid_byte1", 32'(tx_data), 32'h66);
        rstn     = 1'b0;
        tx_ready = 1'b0;
        tick;
        check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        check("mid_rst_tx_data", 32'(tx_data), 32'd0);
        check("mid_rst_rdata", io_rdata, 32'd0);
        check("mid_rst_done", 32'(io_done), 32'd0);
        check("mid_rst_overflow", 32'(rx_overflow), 32'd0);
        rstn = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick;
            if (io_done || tx_valid) seen = 1'b1;
        end
        check("mid_rst_quiet", 32'(seen), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
